// File: rtl/pattern_stream_tx.sv
// Transmit side of the byte-stream pattern-detect link: sends filler, then "boab",
// then handshakes the detector's found flag with an ack toggle and reports done or error.
module pattern_stream_tx #(
  parameter int         PRE_LEN   = 3,
  parameter logic [7:0] FILL_BYTE = 8'h2E,
  parameter int         TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       reset_sync,
  input  logic       start,
  input  logic       end_pol,
  input  logic       found_pattern,
  output logic [7:0] data,
  output logic       ack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] frame_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_B1, S_O, S_A, S_B2, S_WAIT, S_ACK, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0] PRE_LAST = (PRE_LEN > 0) ? 8'(PRE_LEN - 1) : 8'd0;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic       HAS_PRE  = (PRE_LEN > 0);

  state_t     state, nstate;
  logic [7:0] pcnt, pcnt_d;
  logic [7:0] wcnt, wcnt_d;
  logic       ep_q, ep_d;
  logic [7:0] data_d, fcnt_d;
  logic       ack_d, busy_d, done_d, error_d;
  logic       accept;

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state     <= S_IDLE;
      pcnt      <= '0;
      wcnt      <= '0;
      ep_q      <= 1'b0;
      data      <= FILL_BYTE;
      ack       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= nstate;
      pcnt      <= pcnt_d;
      wcnt      <= wcnt_d;
      ep_q      <= ep_d;
      data      <= data_d;
      ack       <= ack_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      frame_cnt <= fcnt_d;
    end
  end

  // Next state; outputs are then derived from the state being entered so they
  // come straight out of flops and line up with the state that holds them.
  always_comb begin
    nstate = state;
    pcnt_d = pcnt;
    wcnt_d = wcnt;
    ep_d   = ep_q;
    accept = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept = 1'b1;
        ep_d   = end_pol;
        pcnt_d = '0;
        nstate = HAS_PRE ? S_PRE : S_B1;
      end
      S_PRE: begin
        if (pcnt == PRE_LAST) nstate = S_B1;
        else                  pcnt_d = pcnt + 8'd1;
      end
      S_B1: nstate = S_O;
      S_O:  nstate = S_A;
      S_A:  nstate = S_B2;
      S_B2: begin
        nstate = S_WAIT;
        wcnt_d = '0;
      end
      S_WAIT: begin
        if (found_pattern)        nstate = S_ACK;
        else if (wcnt == TO_LAST) nstate = S_ERR;
        else                      wcnt_d = wcnt + 8'd1;
      end
      // Flipped ack must have cleared found already; if not, the detector is broken.
      S_ACK:  nstate = found_pattern ? S_ERR : S_DONE;
      S_DONE: nstate = S_IDLE;
      S_ERR:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    data_d = FILL_BYTE;
    ack_d  = 1'b0;
    case (nstate)
      S_B1:   data_d = 8'h62;
      S_O:    data_d = 8'h6F;
      S_A:    data_d = 8'h61;
      S_B2:   begin data_d = 8'h62; ack_d = ep_d; end
      S_WAIT: ack_d = ep_d;
      S_ACK:  ack_d = ~ep_d;
      default: ;
    endcase
    busy_d  = (nstate != S_IDLE);
    done_d  = (nstate == S_DONE);
    error_d = accept ? 1'b0 : (error | (nstate == S_ERR));
    fcnt_d  = (nstate == S_DONE) ? frame_cnt + 8'd1 : frame_cnt;
  end

endmodule

// File: tb/tb_pattern_stream_tx.sv
// Directed bench: two transmitters (PRE_LEN 3 and 0) each driving a behavioural
// "boab" detector model whose found flag holds until ack toggles.
module tb_pattern_stream_tx;
  logic       clk, reset_sync, start, end_pol, sel;
  logic [1:0] fmode;
  logic [7:0] data_a, data_b, fc_a, fc_b, data_o, fc_o;
  logic       ack_a, ack_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic       found_a, found_b, ack_o, busy_o, done_o, err_o, found_o;
  logic [2:0] dst [2];
  logic       dcap [2];
  logic       dfound [2];
  logic [7:0] fc [2];
  int checks, errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pattern_stream_tx #(.PRE_LEN(3)) u_dut_a (
    .clk(clk), .reset_sync(reset_sync), .start(start & ~sel), .end_pol(end_pol),
    .found_pattern(found_a), .data(data_a), .ack(ack_a), .busy(busy_a),
    .done(done_a), .error(err_a), .frame_cnt(fc_a));

  pattern_stream_tx #(.PRE_LEN(0)) u_dut_b (
    .clk(clk), .reset_sync(reset_sync), .start(start & sel), .end_pol(end_pol),
    .found_pattern(found_b), .data(data_b), .ack(ack_b), .busy(busy_b),
    .done(done_b), .error(err_b), .frame_cnt(fc_b));

  // Detector model: 0 idle, 1 'b', 2 'bo', 3 'boa', 4 found (ack level captured)
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] d;
      logic       a;
      d = (i == 0) ? data_a : data_b;
      a = (i == 0) ? ack_a : ack_b;
      if (reset_sync) begin
        dst[i]  <= 3'd0;
        dcap[i] <= 1'b0;
      end else begin
        case (dst[i])
          3'd0: dst[i] <= (d == 8'h62) ? 3'd1 : 3'd0;
          3'd1: dst[i] <= (d == 8'h6F) ? 3'd2 : (d == 8'h62) ? 3'd1 : 3'd0;
          3'd2: dst[i] <= (d == 8'h61) ? 3'd3 : (d == 8'h62) ? 3'd1 : 3'd0;
          3'd3: begin
            dst[i]  <= (d == 8'h62) ? 3'd4 : 3'd0;
            dcap[i] <= a;
          end
          default: if (a != dcap[i]) dst[i] <= 3'd0;
        endcase
      end
    end
  end

  always_comb begin
    dfound[0] = (dst[0] == 3'd4) && (ack_a == dcap[0]);
    dfound[1] = (dst[1] == 3'd4) && (ack_b == dcap[1]);
    found_a   = (fmode == 2'd0) ? dfound[0] : (fmode == 2'd2);
    found_b   = (fmode == 2'd0) ? dfound[1] : (fmode == 2'd2);
    data_o  = sel ? data_b : data_a;
    ack_o   = sel ? ack_b  : ack_a;
    busy_o  = sel ? busy_b : busy_a;
    done_o  = sel ? done_b : done_a;
    err_o   = sel ? err_b  : err_a;
    fc_o    = sel ? fc_b   : fc_a;
    found_o = sel ? found_b : found_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_frame(input logic ep, input int pre, input logic noise);
    logic [7:0] ed;
    logic       ea;
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_data", data_o, 8'h2E);
    start = 1'b1; end_pol = ep;
    tick();
    start = noise;
    for (int k = 1; k <= pre + 7; k++) begin
      ed = 8'h2E; ea = 1'b0;
      if (k == pre + 1) ed = 8'h62;
      if (k == pre + 2) ed = 8'h6F;
      if (k == pre + 3) ed = 8'h61;
      if (k == pre + 4) begin ed = 8'h62; ea = ep; end
      if (k == pre + 5) ea = ep;
      if (k == pre + 6) ea = ~ep;
      chk("data", data_o, ed);
      chk("ack", ack_o, ea);
      chk("done", done_o, k == pre + 7);
      chk("found", found_o, k == pre + 5);
      chk("busy", busy_o, 1'b1);
      chk("error", err_o, 1'b0);
      tick();
    end
    start = 1'b0;
    fc[sel] = fc[sel] + 8'd1;
    chk("frame_cnt", fc_o, fc[sel]);
    chk("post_busy", busy_o, 1'b0);
    chk("post_done", done_o, 1'b0);
  endtask

  task automatic err_frame(input logic ep, input logic [1:0] mode, input int exp_cyc);
    int n;
    fmode = mode;
    start = 1'b1; end_pol = ep;
    tick();
    start = 1'b0;
    chk("err_clr", err_o, 1'b0);
    n = 1;
    while (err_o == 1'b0 && n < 100) begin
      chk("err_nodone", done_o, 1'b0);
      tick();
      n++;
    end
    chk("err_lat", n, exp_cyc);
    chk("err_busy", busy_o, 1'b1);
    chk("err_done", done_o, 1'b0);
    tick();
    fmode = 2'd0;
    chk("err_busy_drop", busy_o, 1'b0);
    chk("err_sticky", err_o, 1'b1);
    chk("err_fc", fc_o, fc[sel]);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_sync = 1'b1; start = 1'b0; end_pol = 1'b0; sel = 1'b0; fmode = 2'd0;
    fc[0] = 8'd0; fc[1] = 8'd0;
    repeat (2) tick();
    chk("rst_data", data_a, 8'h2E);
    chk("rst_ack", ack_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_fc", fc_a, 8'd0);
    chk("rst_data_b", data_b, 8'h2E);
    reset_sync = 1'b0;
    tick();

    // T1, T2: nominal frames, both ack polarities
    run_frame(1'b0, 3, 1'b0);
    run_frame(1'b1, 3, 1'b0);
    // T3: detector silent -> timeout after 15 WAIT cycles
    err_frame(1'b1, 2'd1, 3 + 4 + 15 + 1);
    // T4: found stuck high -> ERR right after ACK
    err_frame(1'b0, 2'd2, 3 + 4 + 1 + 1 + 1);

    // T5: reset mid-frame (during 'o'), start held high throughout
    start = 1'b1; end_pol = 1'b0;
    tick();
    repeat (4) tick();
    chk("t5_in_o", data_o, 8'h6F);
    reset_sync = 1'b1;
    tick();
    chk("t5_data", data_o, 8'h2E);
    chk("t5_ack", ack_o, 1'b0);
    chk("t5_busy", busy_o, 1'b0);
    chk("t5_fc", fc_o, 8'd0);
    chk("t5_err", err_o, 1'b0);
    reset_sync = 1'b0; start = 1'b0;
    fc[0] = 8'd0;
    tick();
    chk("t5_idle", busy_o, 1'b0);
    run_frame(1'b1, 3, 1'b1);
    tick();
    chk("t5_one_frame", busy_o, 1'b0);

    // T6: PRE_LEN=0, 256 back-to-back frames, counter wraps
    sel = 1'b1;
    for (int f = 0; f < 256; f++) run_frame(f[0], 0, 1'b0);
    chk("t6_wrap", fc_o, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
